// File: rtl/display_source_arbiter_if.sv
// Bundle between display requesters and the display source arbiter.
// Requesters drive levels and values; the arbiter returns the registered grant and display drive.
interface display_source_arbiter_if #(
  parameter int unsigned NUM_SRC = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]   req;
  logic [8*NUM_SRC-1:0] src_value;
  logic [NUM_SRC-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [7:0]           binary;
  logic                 blank;
  logic                 switch_pulse;

  modport master (
    output req, src_value,
    input  grant, grant_idx, binary, blank, switch_pulse
  );

  modport slave (
    input  req, src_value,
    output grant, grant_idx, binary, blank, switch_pulse
  );
endinterface

// File: rtl/display_source_arbiter.sv
// Round-robin sharing of one seven-segment display among NUM_SRC requesters,
// with a minimum dwell per grant and a blank gap between different sources.
module display_source_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 20_000_000,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  display_source_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] last;

  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic             other_req;
  logic             release_now;
  logic             start_show;
  int unsigned      probe;

  function automatic logic [7:0] sel_value(input logic [8*NUM_SRC-1:0] v,
                                           input logic [IDX_W-1:0]     i);
    return 8'(v >> {i, 3'b000});
  endfunction

  // Nearest requester after the last granted one, wrapping around.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    probe     = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      probe = (32'(last) + k) % NUM_SRC;
      if (!win_valid && bus.req[IDX_W'(probe)]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(probe);
      end
    end
  end

  always_comb begin
    other_req   = |(bus.req & ~bus.grant);
    release_now = (state == SHOW) &&
                  (!bus.req[bus.grant_idx] || ((dwell_cnt == DWELL_LAST) && other_req));
    start_show  = win_valid &&
                  ((state == IDLE) || ((state == GAP) && (gap_cnt == GAP_LAST)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.grant        <= '0;
      bus.grant_idx    <= '0;
      bus.binary       <= '0;
      bus.blank        <= 1'b1;
      bus.switch_pulse <= 1'b0;
      dwell_cnt        <= '0;
      gap_cnt          <= '0;
      last             <= IDX_W'(NUM_SRC - 1);
    end else begin
      bus.switch_pulse <= 1'b0;
      if (start_show) begin
        state            <= SHOW;
        bus.grant        <= NUM_SRC'(1) << win_idx;
        bus.grant_idx    <= win_idx;
        last             <= win_idx;
        bus.binary       <= sel_value(bus.src_value, win_idx);
        bus.blank        <= 1'b0;
        bus.switch_pulse <= 1'b1;
        dwell_cnt        <= '0;
      end else if (release_now) begin
        // Early release and dwell expiry with a waiting competitor both blank here.
        state         <= (GAP_CYCLES > 0) ? GAP : IDLE;
        bus.grant     <= '0;
        bus.grant_idx <= '0;
        bus.binary    <= '0;
        bus.blank     <= 1'b1;
        dwell_cnt     <= '0;
        gap_cnt       <= '0;
      end else begin
        case (state)
          SHOW: begin
            bus.binary <= sel_value(bus.src_value, bus.grant_idx);
            dwell_cnt  <= (dwell_cnt == DWELL_LAST) ? '0 : CNT_W'(dwell_cnt + 1'b1);
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) state <= IDLE;
            else gap_cnt <= GAP_W'(gap_cnt + 1'b1);
          end
          IDLE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter (NUM_SRC=4, DWELL_CYCLES=8, GAP_CYCLES=2).
module tb_display_source_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  display_source_arbiter_if #(.NUM_SRC(4)) bus ();

  display_source_arbiter #(
    .NUM_SRC(4), .DWELL_CYCLES(8), .GAP_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic [7:0] b, input logic bl, input logic p);
    chk({tag, ".grant"},        8'(bus.grant),        8'(g));
    chk({tag, ".grant_idx"},    8'(bus.grant_idx),    8'(idx));
    chk({tag, ".binary"},       bus.binary,           b);
    chk({tag, ".blank"},        8'(bus.blank),        8'(bl));
    chk({tag, ".switch_pulse"}, 8'(bus.switch_pulse), 8'(p));
  endtask

  task automatic set_val(input int i, input logic [7:0] v);
    bus.src_value[8*i +: 8] = v;
  endtask

  logic [7:0] rot_val [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.req = '0;
    bus.src_value = '0;
    #2 rst = 1'b1;
    #2 check_out("reset", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    check_out("idle", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);

    // single request, negative value
    set_val(2, 8'h82);
    bus.req = 4'b0100;
    step();
    check_out("single.enter", 4'b0100, 2'd2, 8'h82, 1'b0, 1'b1);
    step();
    check_out("single.hold", 4'b0100, 2'd2, 8'h82, 1'b0, 1'b0);
    bus.req = 4'b0000;
    step();
    check_out("single.gap1", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
    step();
    step();
    check_out("single.idle", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);

    // early release of src1 at dwell count 3, then src3 requested during gap
    set_val(1, 8'h11);
    set_val(3, 8'h7F);
    bus.req = 4'b0010;
    step();
    check_out("early.enter", 4'b0010, 2'd1, 8'h11, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      step();
      check_out($sformatf("early.cnt%0d", c), 4'b0010, 2'd1, 8'h11, 1'b0, 1'b0);
    end
    bus.req = 4'b0000;
    step();
    check_out("early.gap1", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
    bus.req = 4'b1000;
    step();
    check_out("early.gap2", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
    step();
    check_out("early.src3", 4'b1000, 2'd3, 8'h7F, 1'b0, 1'b1);
    bus.req = 4'b0000;
    step();
    step();
    step();
    check_out("early.idle", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);

    // live value change, then sole holder across several dwell periods
    set_val(0, 8'd38);
    bus.req = 4'b0001;
    step();
    check_out("live.enter", 4'b0001, 2'd0, 8'h26, 1'b0, 1'b1);
    set_val(0, 8'hFF);
    #1 chk("live.no_comb_path", bus.binary, 8'h26);
    step();
    check_out("live.update", 4'b0001, 2'd0, 8'hFF, 1'b0, 1'b0);
    for (int c = 0; c < 30; c++) begin
      step();
      check_out($sformatf("sole.c%0d", c), 4'b0001, 2'd0, 8'hFF, 1'b0, 1'b0);
    end

    // asynchronous reset mid-SHOW
    #2 rst = 1'b1;
    #1 check_out("rst.async", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    rst = 1'b0;
    step();
    step();
    check_out("rst.idle", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);

    // full rotation with every source requesting
    rot_val[0] = 8'h01;
    rot_val[1] = 8'h80;
    rot_val[2] = 8'h03;
    rot_val[3] = 8'hFB;
    for (int i = 0; i < 4; i++) set_val(i, rot_val[i]);
    bus.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      int g;
      g = r % 4;
      step();
      check_out($sformatf("rot%0d.enter", r), 4'(1 << g), 2'(g), rot_val[g], 1'b0, 1'b1);
      if (r < 4) begin
        for (int c = 1; c < 8; c++) begin
          step();
          check_out($sformatf("rot%0d.c%0d", r, c), 4'(1 << g), 2'(g), rot_val[g], 1'b0, 1'b0);
        end
        for (int c = 1; c <= 2; c++) begin
          step();
          check_out($sformatf("rot%0d.gap%0d", r, c), 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
